// File: rtl/sp1_ff_arb_if.sv
// sp1_ff_arb_if: requester/grant/register bundle shared by the arbiter and its driver.
interface sp1_ff_arb_if #(parameter int DW = 32);
    logic [3:0]    req;
    logic [3:0]    lock;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    gnt;
    logic [DW-1:0] q;
    logic          locked;
    logic [1:0]    owner;
    modport slave  (input req, lock, d0, d1, d2, d3, output gnt, q, locked, owner);
    modport master (output req, lock, d0, d1, d2, d3, input gnt, q, locked, owner);
endinterface

// File: rtl/sp1_ff_arb.sv
// sp1_ff_arb: round-robin arbiter with per-requester lock, writing a shared register.
module sp1_ff #(parameter int DW = 32) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q_o <= '0;
        else if (en) q_o <= d_i;
endmodule

module sp1_ff_arb #(parameter int DW = 32) (
    input logic          clk,
    input logic          rst,
    sp1_ff_arb_if.slave  arb
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d, owner_q, owner_d, gi;
    logic [3:0]    rot, pick, gnt;
    logic [DW-1:0] wdata;
    // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
    always_comb begin
        rot   = 4'(({arb.req, arb.req}) >> ptr_q);
        pick  = rot & (~rot + 4'd1);
        gnt   = rst ? 4'b0 :
                state_q == LOCKED ? (arb.req[owner_q] ? 4'b1 << owner_q : 4'b0) :
                4'(({pick, pick} << ptr_q) >> 4);
        gi    = gnt[3] ? 2'd3 : gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
        wdata = gi == 2'd3 ? arb.d3 : gi == 2'd2 ? arb.d2 : gi == 2'd1 ? arb.d1 : arb.d0;
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (state_q == IDLE) begin
            if (|gnt) begin
                if (arb.lock[gi]) begin
                    state_d = LOCKED;
                    owner_d = gi;
                end else ptr_d = gi + 2'd1;
            end
        end else if (!(arb.req[owner_q] && arb.lock[owner_q])) begin
            state_d = IDLE;
            ptr_d   = owner_q + 2'd1;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    sp1_ff #(.DW(DW)) u_reg (.clk(clk), .rst(rst), .en(|gnt), .d_i(wdata), .q_o(arb.q));
    assign arb.gnt    = gnt;
    assign arb.locked = state_q == LOCKED;
    assign arb.owner  = owner_q;
endmodule

// File: tb/tb_sp1_ff_arb.sv
// tb_sp1_ff_arb: directed vectors feed a scoreboard queue; a monitor pops and compares each cycle.
module tb_sp1_ff_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sp1_ff_arb_if #(.DW(32)) arb ();
    sp1_ff_arb #(.DW(32)) dut (.clk(clk), .rst(rst), .arb(arb));
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gnt;
        logic [31:0] q;
        logic        locked;
        logic [1:0]  owner;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle at posedge+2; returns at the next posedge+2
    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg,
                       input logic [31:0] eq, input logic el, input logic [1:0] eo);
        exp_t e;
        arb.req  = r;
        arb.lock = l;
        e.gnt = eg; e.q = eq; e.locked = el; e.owner = eo;
        sb.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", {28'd0, arb.gnt}, 32'd0);
        chk("rst_q", arb.q, 32'd0);
        chk("rst_locked", {31'd0, arb.locked}, 32'd0);
        chk("rst_owner", {30'd0, arb.owner}, 32'd0);
        @(posedge clk); #1;
        chk("rst_q_hold", arb.q, 32'd0);
        chk("rst_gnt_hold", {28'd0, arb.gnt}, 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("gnt", {28'd0, arb.gnt}, {28'd0, e.gnt});
                @(posedge clk); #1;
                chk("q", arb.q, e.q);
                chk("locked", {31'd0, arb.locked}, {31'd0, e.locked});
                chk("owner", {30'd0, arb.owner}, {30'd0, e.owner});
            end
        end
    end

    initial begin
        arb.req = 4'b1111; arb.lock = 4'b0000;
        arb.d0 = 32'hffffffff; arb.d1 = 32'h11111111; arb.d2 = 32'd0; arb.d3 = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        do_reset();
        cyc(4'b0001, 4'b0000, 4'b0001, 32'hffffffff, 1'b0, 2'd0);
        cyc(4'b0011, 4'b0000, 4'b0010, 32'h11111111, 1'b0, 2'd0);
        do_reset();
        arb.d0 = 32'h00000000; arb.d1 = 32'h12345678; arb.d2 = 32'hcafecafe; arb.d3 = 32'hbeefbeef;
        cyc(4'b1111, 4'b0000, 4'b0001, 32'h00000000, 1'b0, 2'd0);
        cyc(4'b1111, 4'b0000, 4'b0010, 32'h12345678, 1'b0, 2'd0);
        cyc(4'b1111, 4'b0000, 4'b0100, 32'hcafecafe, 1'b0, 2'd0);
        cyc(4'b1111, 4'b0000, 4'b1000, 32'hbeefbeef, 1'b0, 2'd0);
        cyc(4'b1111, 4'b0000, 4'b0001, 32'h00000000, 1'b0, 2'd0);
        cyc(4'b0100, 4'b0000, 4'b0100, 32'hcafecafe, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000, 4'b0000, 32'hcafecafe, 1'b0, 2'd0);
        do_reset();
        cyc(4'b0001, 4'b0000, 4'b0001, 32'h00000000, 1'b0, 2'd0);
        arb.d1 = 32'ha1a1a1a1;
        cyc(4'b0011, 4'b0010, 4'b0010, 32'ha1a1a1a1, 1'b1, 2'd1);
        arb.d1 = 32'ha2a2a2a2;
        cyc(4'b0011, 4'b0010, 4'b0010, 32'ha2a2a2a2, 1'b1, 2'd1);
        arb.d1 = 32'ha3a3a3a3;
        cyc(4'b0011, 4'b0010, 4'b0010, 32'ha3a3a3a3, 1'b1, 2'd1);
        arb.d1 = 32'ha4a4a4a4;
        cyc(4'b0011, 4'b0000, 4'b0010, 32'ha4a4a4a4, 1'b0, 2'd1);
        cyc(4'b0011, 4'b0000, 4'b0001, 32'h00000000, 1'b0, 2'd1);
        cyc(4'b0100, 4'b0100, 4'b0100, 32'hcafecafe, 1'b1, 2'd2);
        cyc(4'b0011, 4'b0000, 4'b0000, 32'hcafecafe, 1'b0, 2'd2);
        cyc(4'b1011, 4'b0000, 4'b1000, 32'hbeefbeef, 1'b0, 2'd2);
        arb.d0 = 32'h5a5a5a5a;
        cyc(4'b1111, 4'b1111, 4'b0001, 32'h5a5a5a5a, 1'b1, 2'd0);
        cyc(4'b1111, 4'b1111, 4'b0001, 32'h5a5a5a5a, 1'b1, 2'd0);
        do_reset();
        cyc(4'b1111, 4'b0000, 4'b0001, 32'h5a5a5a5a, 1'b0, 2'd0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sp1_ff_arb.md
SP1_FF_ARB -- requirements
Module: sp1_ff_arb

Interface
REQ-001 Parameter: DW, default 32, data width of the shared register.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  write request, one bit per requester 0..3.
REQ-005 lock  input  4  per-requester lock request; sampled only with the matching req bit.
REQ-006 d0, d1, d2, d3  input  DW each  write data of requesters 0..3.
REQ-007 gnt  output  4  grant, one-hot or zero, combinational from req, lock state and priority pointer.
REQ-008 q  output  DW  shared register contents, registered.
REQ-009 locked  output  1  high while the FSM is in LOCKED.
REQ-010 owner  output  2  index of the lock holder; valid only while locked=1.

Function
REQ-011 The shared register SHALL be an sp1_ff #(DW) instance, with en=|gnt and d=data of the granted requester.
REQ-012 FSM states SHALL be IDLE and LOCKED, with a 2-bit priority pointer ptr.
REQ-013 IDLE: gnt SHALL select the first asserted req bit, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); gnt=0 when req=0.
REQ-014 LOCKED: gnt[owner] SHALL equal req[owner], and all other gnt bits SHALL be 0.
REQ-015 On a posedge with gnt[i]=1, q SHALL take di; write latency is 1 cycle (q valid after the edge).
REQ-016 On a posedge with gnt=0, q SHALL hold its value.
REQ-017 IDLE, grant to i with lock[i]=1: next state LOCKED, owner<=i, ptr unchanged.
REQ-018 IDLE, grant to i with lock[i]=0: state stays IDLE and ptr<=i+1 mod 4 (wraps 3->0).
REQ-019 LOCKED, req[owner]=1 and lock[owner]=1: the write occurs and state stays LOCKED.
REQ-020 LOCKED, req[owner]=1 and lock[owner]=0: the write occurs, next state IDLE, ptr<=owner+1.
REQ-021 LOCKED, req[owner]=0: no write, next state IDLE, ptr<=owner+1 (release without write).
REQ-022 Requests from non-owners while LOCKED SHALL be held off, with no gnt and no loss of priority position.
REQ-023 locked SHALL be registered and equal (state==LOCKED); owner SHALL hold its value after leaving LOCKED.
REQ-024 Simultaneous requests SHALL receive exactly one grant per cycle; gnt SHALL never have more than one bit set.
REQ-025 An X on the selected req or lock bit SHALL propagate X to q/state in simulation and SHALL NOT be masked.

Reset
REQ-026 While rst=1: q=0, gnt=0 (forced regardless of req), state=IDLE, locked=0, owner=0, ptr=0.
REQ-027 rst asserted mid-lock or mid-write SHALL return all of REQ-026 immediately, with no pending write completing.
REQ-028 The first posedge after rst falls SHALL arbitrate normally from ptr=0.

Verification
REQ-029 After reset, req=0001, d0=ffffffff for one cycle -> gnt=0001 that cycle, q=ffffffff after the edge, ptr=1.
REQ-030 After reset, req=1111 held 5 cycles, d0..d3=00000000, 12345678, cafecafe, beefbeef -> gnt=0001, 0010, 0100, 1000, 0001; q follows one cycle later.
REQ-031 req=0011, lock=0010, with ptr at 1 -> gnt=0010 for 3 cycles while lock[1]=1, locked=1, owner=1, req0 starved; lock[1]=0 -> last write, then gnt=0001.
REQ-032 LOCKED with owner=2, then req[2] drops -> no write, locked=0 next cycle, ptr=3, q unchanged.
REQ-033 rst pulsed while locked=1 with req=1111 held -> q=0, gnt=0, locked=0 during rst; after rst gnt=0001 first.
REQ-034 req=0000 for 4 cycles after q=cafecafe -> gnt=0, q stays cafecafe, locked=0.
